axi_sram_bridge: RTL and testbench
==================================

AXI_SRAM_BRIDGE -- requirements
Module: axi_sram_bridge

Interface
REQ-001 SHALL have parameter SRAM_LAT, default 1: cycles from io_sram_en/re assertion to sampling io_sram_dout, range 1..7.
REQ-002 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port group io_axi_ar_{id,addr,len,size,burst,valid}, input, 8/32/8/3/2/1: AXI4 read address; io_axi_ar_ready, output, 1.
REQ-005 SHALL have port group io_axi_r_{id,resp,data,last,valid}, output, 8/2/32/1/1: read data; io_axi_r_ready, input, 1.
REQ-006 SHALL have port group io_axi_aw_{id,addr,len,size,burst,valid}, input, 8/32/8/3/2/1: write address; io_axi_aw_ready, output, 1.
REQ-007 SHALL have port group io_axi_w_{data,strb,last,valid}, input, 32/4/1/1: write data; io_axi_w_ready, output, 1.
REQ-008 SHALL have port group io_axi_b_{id,resp,valid}, output, 8/2/1: write response; io_axi_b_ready, input, 1.
REQ-009 SHALL have port group io_sram_{addr,din,en,re,we,wmask}, output, 20/32/1/1/1/4, and io_sram_dout, input, 32: word SRAM port.

Function
REQ-010 SHALL serve one transaction at a time; FSM states IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP.
REQ-011 SHALL in IDLE assert ar_ready/aw_ready; if both valid in one cycle, grant alternates, starting with read after reset; only granted channel sees ready high.
REQ-012 SHALL latch id, addr, len, burst at handshake; io_sram_addr = word address addr[21:2].
REQ-013 SHALL for burst INCR (01) and WRAP (10) add 1 to the word address per beat, wrapping modulo 2^20; FIXED (00) holds address.
REQ-014 SHALL per read beat assert io_sram_en and io_sram_re for SRAM_LAT cycles (RD_ISSUE then RD_WAIT), then register io_sram_dout into r_data.
REQ-015 SHALL in RD_RESP hold r_valid and r_data/id/resp stable until r_ready; r_last high on beat len+1; first r_valid exactly 1+SRAM_LAT cycles after AR handshake.
REQ-016 SHALL in WR_DATA assert w_ready; on W handshake drive io_sram_en=we=1, wmask=w_strb, din=w_data for exactly one cycle, w_ready low that cycle.
REQ-017 SHALL count write beats from aw_len, ignoring w_last for termination; after beat len+1 enter WR_RESP with b_valid held until b_ready.
REQ-018 SHALL return resp OKAY (00) unless the REQ-026 error feature applies.
REQ-019 SHALL keep io_sram_en, re, we low and wmask 0 in IDLE, RD_RESP, WR_RESP.
REQ-020 SHALL return to IDLE after R last or B handshake and accept a new request the following cycle.
REQ-021 SHALL treat r_ready/b_ready held low indefinitely as stall with no SRAM activity.

Reset
REQ-022 SHALL on rst_n low immediately force IDLE and drive all ready/valid, io_sram_en/re/we low, wmask 0, r_data/id/resp/last and b_id/resp 0.
REQ-023 SHALL abandon any in-flight burst at reset with no response generated afterward.
REQ-024 SHALL deassert ar_ready/aw_ready until the first clock edge after rst_n rises.

Configuration
REQ-025 SHALL compile the error check only when macro AXI_SRAM_BRIDGE_ERRCHK_EN is defined.
REQ-026 SHALL with macro: size != 3'b010 or burst == 2'b11 yields resp SLVERR (10) on every R beat with data 0 and no SRAM access, or on B with io_sram_we suppressed; w_last mismatch with beat count yields SLVERR on B.
REQ-027 SHALL without macro: all transactions OKAY, size ignored, burst 11 treated as INCR, w_last ignored.

Verification
REQ-028 SHALL test single read: ar addr 0x0000_0010 len 0, SRAM_LAT 1, dout 0xDEADBEEF -> io_sram_addr 0x00004, r_valid 2 cycles after handshake, r_data 0xDEADBEEF, r_last 1, resp 00.
REQ-029 SHALL test INCR write burst: aw addr 0x100 len 3, strb 4'b1111 -> we pulses on sram addr 0x40..0x43, one b_valid with matching id.
REQ-030 SHALL test simultaneous ar_valid and aw_valid after reset -> read granted first, write granted on next IDLE.
REQ-031 SHALL test backpressure: r_ready low 5 cycles on beat 2 of len 3 read -> r_data stable, no SRAM en during stall.
REQ-032 SHALL test wrap: INCR len 1 at addr 0x003F_FFFC -> sram addr 0xFFFFF then 0x00000.
REQ-033 SHALL test rst_n low mid write burst -> all outputs zero same cycle, no b_valid after release; with macro, size 3'b000 read -> SLVERR, data 0.

Source files
------------

// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: single-outstanding AXI4 slave driving a word-wide SRAM port.
// Define AXI_SRAM_BRIDGE_ERRCHK_EN to answer bad size/burst and w_last mismatches with SLVERR.
module axi_sram_bridge #(
    parameter int SRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  io_axi_ar_id,
    input  logic [31:0] io_axi_ar_addr,
    input  logic [7:0]  io_axi_ar_len,
    input  logic [2:0]  io_axi_ar_size,
    input  logic [1:0]  io_axi_ar_burst,
    input  logic        io_axi_ar_valid,
    output logic        io_axi_ar_ready,
    output logic [7:0]  io_axi_r_id,
    output logic [1:0]  io_axi_r_resp,
    output logic [31:0] io_axi_r_data,
    output logic        io_axi_r_last,
    output logic        io_axi_r_valid,
    input  logic        io_axi_r_ready,
    input  logic [7:0]  io_axi_aw_id,
    input  logic [31:0] io_axi_aw_addr,
    input  logic [7:0]  io_axi_aw_len,
    input  logic [2:0]  io_axi_aw_size,
    input  logic [1:0]  io_axi_aw_burst,
    input  logic        io_axi_aw_valid,
    output logic        io_axi_aw_ready,
    input  logic [31:0] io_axi_w_data,
    input  logic [3:0]  io_axi_w_strb,
    input  logic        io_axi_w_last,
    input  logic        io_axi_w_valid,
    output logic        io_axi_w_ready,
    output logic [7:0]  io_axi_b_id,
    output logic [1:0]  io_axi_b_resp,
    output logic        io_axi_b_valid,
    input  logic        io_axi_b_ready,
    output logic [19:0] io_sram_addr,
    output logic [31:0] io_sram_din,
    output logic        io_sram_en,
    output logic        io_sram_re,
    output logic        io_sram_we,
    output logic [3:0]  io_sram_wmask,
    input  logic [31:0] io_sram_dout
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

    localparam logic [2:0] LAT_M1      = 3'(SRAM_LAT - 1);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_reg, state_next;
    logic        prefer_rd_reg, prefer_rd_next;
    logic        ready_en_reg;
    logic [7:0]  id_reg, id_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  beat_reg, beat_next;
    logic [19:0] addr_reg, addr_next;
    logic [1:0]  burst_reg, burst_next;
    logic [2:0]  lat_cnt_reg, lat_cnt_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] din_reg, din_next;
    logic [3:0]  wmask_reg, wmask_next;
    logic        pulse_reg, pulse_next;
    logic        err_reg, err_next;
    logic        wlast_err_reg, wlast_err_next;

    logic        idle_ok, ar_hs, aw_hs, w_hs, last_beat;
    logic        ar_bad, aw_bad, wlast_bad;
    logic        rd_act, wr_act;
    logic [19:0] addr_step;

`ifdef AXI_SRAM_BRIDGE_ERRCHK_EN
    assign ar_bad    = (io_axi_ar_size != 3'b010) || (io_axi_ar_burst == 2'b11);
    assign aw_bad    = (io_axi_aw_size != 3'b010) || (io_axi_aw_burst == 2'b11);
    assign wlast_bad = (io_axi_w_last != last_beat);
`else
    assign ar_bad    = 1'b0;
    assign aw_bad    = 1'b0;
    assign wlast_bad = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{io_axi_ar_size, io_axi_aw_size, io_axi_w_last};
`endif

    logic unused_addr;
    assign unused_addr = ^{io_axi_ar_addr[31:22], io_axi_ar_addr[1:0],
                           io_axi_aw_addr[31:22], io_axi_aw_addr[1:0]};

    // ready stays low until the first edge after reset release
    assign idle_ok         = (state_reg == IDLE) && ready_en_reg;
    assign io_axi_ar_ready = idle_ok && (!io_axi_aw_valid || prefer_rd_reg);
    assign io_axi_aw_ready = idle_ok && (!io_axi_ar_valid || !prefer_rd_reg);
    assign io_axi_w_ready  = (state_reg == WR_DATA) && !pulse_reg;
    assign ar_hs           = io_axi_ar_valid && io_axi_ar_ready;
    assign aw_hs           = io_axi_aw_valid && io_axi_aw_ready;
    assign w_hs            = io_axi_w_valid && io_axi_w_ready;
    assign last_beat       = (beat_reg == len_reg);
    assign addr_step       = (burst_reg == BURST_FIXED) ? addr_reg : addr_reg + 20'd1;

    assign io_axi_r_valid = (state_reg == RD_RESP);
    assign io_axi_r_id    = id_reg;
    assign io_axi_r_data  = data_reg;
    assign io_axi_r_resp  = err_reg ? RESP_SLVERR : RESP_OKAY;
    assign io_axi_r_last  = io_axi_r_valid && last_beat;
    assign io_axi_b_valid = (state_reg == WR_RESP);
    assign io_axi_b_id    = id_reg;
    assign io_axi_b_resp  = (err_reg || wlast_err_reg) ? RESP_SLVERR : RESP_OKAY;

    assign rd_act        = ((state_reg == RD_ISSUE) || (state_reg == RD_WAIT)) && !err_reg;
    assign wr_act        = (state_reg == WR_DATA) && pulse_reg && !err_reg;
    assign io_sram_addr  = addr_reg;
    assign io_sram_din   = din_reg;
    assign io_sram_en    = rd_act || wr_act;
    assign io_sram_re    = rd_act;
    assign io_sram_we    = wr_act;
    assign io_sram_wmask = wr_act ? wmask_reg : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            prefer_rd_reg <= 1'b1;
            ready_en_reg  <= 1'b0;
            id_reg        <= '0;
            len_reg       <= '0;
            beat_reg      <= '0;
            addr_reg      <= '0;
            burst_reg     <= '0;
            lat_cnt_reg   <= '0;
            data_reg      <= '0;
            din_reg       <= '0;
            wmask_reg     <= '0;
            pulse_reg     <= 1'b0;
            err_reg       <= 1'b0;
            wlast_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prefer_rd_reg <= prefer_rd_next;
            ready_en_reg  <= 1'b1;
            id_reg        <= id_next;
            len_reg       <= len_next;
            beat_reg      <= beat_next;
            addr_reg      <= addr_next;
            burst_reg     <= burst_next;
            lat_cnt_reg   <= lat_cnt_next;
            data_reg      <= data_next;
            din_reg       <= din_next;
            wmask_reg     <= wmask_next;
            pulse_reg     <= pulse_next;
            err_reg       <= err_next;
            wlast_err_reg <= wlast_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        prefer_rd_next = prefer_rd_reg;
        id_next        = id_reg;
        len_next       = len_reg;
        beat_next      = beat_reg;
        addr_next      = addr_reg;
        burst_next     = burst_reg;
        lat_cnt_next   = lat_cnt_reg;
        data_next      = data_reg;
        din_next       = din_reg;
        wmask_next     = wmask_reg;
        pulse_next     = pulse_reg;
        err_next       = err_reg;
        wlast_err_next = wlast_err_reg;
        case (state_reg)
            IDLE: begin
                if (idle_ok && io_axi_ar_valid && io_axi_aw_valid)
                    prefer_rd_next = !prefer_rd_reg;
                if (ar_hs) begin
                    id_next        = io_axi_ar_id;
                    addr_next      = io_axi_ar_addr[21:2];
                    len_next       = io_axi_ar_len;
                    burst_next     = io_axi_ar_burst;
                    beat_next      = 8'd0;
                    err_next       = ar_bad;
                    wlast_err_next = 1'b0;
                    state_next     = RD_ISSUE;
                end else if (aw_hs) begin
                    id_next        = io_axi_aw_id;
                    addr_next      = io_axi_aw_addr[21:2];
                    len_next       = io_axi_aw_len;
                    burst_next     = io_axi_aw_burst;
                    beat_next      = 8'd0;
                    err_next       = aw_bad;
                    wlast_err_next = 1'b0;
                    pulse_next     = 1'b0;
                    state_next     = WR_DATA;
                end
            end
            RD_ISSUE: begin
                if (LAT_M1 == 3'd0) begin
                    data_next  = err_reg ? 32'd0 : io_sram_dout;
                    state_next = RD_RESP;
                end else begin
                    lat_cnt_next = 3'd1;
                    state_next   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_reg == LAT_M1) begin
                    data_next  = err_reg ? 32'd0 : io_sram_dout;
                    state_next = RD_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 3'd1;
                end
            end
            RD_RESP: begin
                if (io_axi_r_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        beat_next  = beat_reg + 8'd1;
                        addr_next  = addr_step;
                        state_next = RD_ISSUE;
                    end
                end
            end
            WR_DATA: begin
                // the cycle after each W handshake is the SRAM write pulse
                if (pulse_reg) begin
                    pulse_next = 1'b0;
                    if (last_beat) begin
                        state_next = WR_RESP;
                    end else begin
                        beat_next = beat_reg + 8'd1;
                        addr_next = addr_step;
                    end
                end else if (w_hs) begin
                    din_next       = io_axi_w_data;
                    wmask_next     = io_axi_w_strb;
                    pulse_next     = 1'b1;
                    wlast_err_next = wlast_err_reg || wlast_bad;
                end
            end
            WR_RESP: begin
                if (io_axi_b_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge: grant order, bursts, wrap, backpressure, reset, error option.
module tb_axi_sram_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  io_axi_ar_id, io_axi_aw_id;
    logic [31:0] io_axi_ar_addr, io_axi_aw_addr;
    logic [7:0]  io_axi_ar_len, io_axi_aw_len;
    logic [2:0]  io_axi_ar_size, io_axi_aw_size;
    logic [1:0]  io_axi_ar_burst, io_axi_aw_burst;
    logic        io_axi_ar_valid, io_axi_aw_valid;
    logic        io_axi_ar_ready, io_axi_aw_ready;
    logic [7:0]  io_axi_r_id, io_axi_b_id;
    logic [1:0]  io_axi_r_resp, io_axi_b_resp;
    logic [31:0] io_axi_r_data;
    logic        io_axi_r_last, io_axi_r_valid, io_axi_r_ready;
    logic [31:0] io_axi_w_data;
    logic [3:0]  io_axi_w_strb;
    logic        io_axi_w_last, io_axi_w_valid, io_axi_w_ready;
    logic        io_axi_b_valid, io_axi_b_ready;
    logic [19:0] io_sram_addr;
    logic [31:0] io_sram_din, io_sram_dout;
    logic        io_sram_en, io_sram_re, io_sram_we;
    logic [3:0]  io_sram_wmask;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rv_cyc = 0;
    logic [19:0] rd_log[$];
    logic [19:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [3:0]  wm_log[$];

    always #5 clk = ~clk;

    // SRAM model: word 4 holds 0xDEADBEEF, every other word reads back as {12'hC0D, addr}
    assign io_sram_dout = (io_sram_addr == 20'h00004) ? 32'hDEAD_BEEF : {12'hC0D, io_sram_addr};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io_sram_en && io_sram_re)
            rd_log.push_back(io_sram_addr);
        if (io_sram_en && io_sram_we) begin
            wa_log.push_back(io_sram_addr);
            wd_log.push_back(io_sram_din);
            wm_log.push_back(io_sram_wmask);
        end
    end

    axi_sram_bridge #(.SRAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .io_axi_ar_id(io_axi_ar_id), .io_axi_ar_addr(io_axi_ar_addr), .io_axi_ar_len(io_axi_ar_len),
        .io_axi_ar_size(io_axi_ar_size), .io_axi_ar_burst(io_axi_ar_burst),
        .io_axi_ar_valid(io_axi_ar_valid), .io_axi_ar_ready(io_axi_ar_ready),
        .io_axi_r_id(io_axi_r_id), .io_axi_r_resp(io_axi_r_resp), .io_axi_r_data(io_axi_r_data),
        .io_axi_r_last(io_axi_r_last), .io_axi_r_valid(io_axi_r_valid), .io_axi_r_ready(io_axi_r_ready),
        .io_axi_aw_id(io_axi_aw_id), .io_axi_aw_addr(io_axi_aw_addr), .io_axi_aw_len(io_axi_aw_len),
        .io_axi_aw_size(io_axi_aw_size), .io_axi_aw_burst(io_axi_aw_burst),
        .io_axi_aw_valid(io_axi_aw_valid), .io_axi_aw_ready(io_axi_aw_ready),
        .io_axi_w_data(io_axi_w_data), .io_axi_w_strb(io_axi_w_strb), .io_axi_w_last(io_axi_w_last),
        .io_axi_w_valid(io_axi_w_valid), .io_axi_w_ready(io_axi_w_ready),
        .io_axi_b_id(io_axi_b_id), .io_axi_b_resp(io_axi_b_resp), .io_axi_b_valid(io_axi_b_valid),
        .io_axi_b_ready(io_axi_b_ready),
        .io_sram_addr(io_sram_addr), .io_sram_din(io_sram_din), .io_sram_en(io_sram_en),
        .io_sram_re(io_sram_re), .io_sram_we(io_sram_we), .io_sram_wmask(io_sram_wmask),
        .io_sram_dout(io_sram_dout)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        io_axi_ar_id = id; io_axi_ar_addr = addr; io_axi_ar_len = len;
        io_axi_ar_size = size; io_axi_ar_burst = burst; io_axi_ar_valid = 1'b1;
        #1;
        while (!io_axi_ar_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk_val("ar_ready_seen", 32'(io_axi_ar_ready), 32'd1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        io_axi_ar_valid = 1'b0;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        io_axi_aw_id = id; io_axi_aw_addr = addr; io_axi_aw_len = len;
        io_axi_aw_size = size; io_axi_aw_burst = burst; io_axi_aw_valid = 1'b1;
        #1;
        while (!io_axi_aw_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk_val("aw_ready_seen", 32'(io_axi_aw_ready), 32'd1);
        @(posedge clk);
        #1 io_axi_aw_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] ed, input logic el, input logic [1:0] er,
                          input logic [7:0] eid, input int stall);
        int n = 0;
        @(negedge clk);
        while (!io_axi_r_valid && n < 40) begin @(negedge clk); n++; end
        chk_val("r_valid_seen", 32'(io_axi_r_valid), 32'd1);
        rv_cyc = cyc;
        for (int i = 0; i < stall; i++) begin
            chk_val("r_stall_valid", 32'(io_axi_r_valid), 32'd1);
            chk_val("r_stall_data", io_axi_r_data, ed);
            chk_val("r_stall_sram_en", 32'(io_sram_en), 32'd0);
            @(negedge clk);
        end
        chk_val("r_data", io_axi_r_data, ed);
        chk_val("r_last", 32'(io_axi_r_last), 32'(el));
        chk_val("r_resp", 32'(io_axi_r_resp), 32'(er));
        chk_val("r_id", 32'(io_axi_r_id), 32'(eid));
        $display("R  id=%h data=%h resp=%b last=%b", io_axi_r_id, io_axi_r_data, io_axi_r_resp, io_axi_r_last);
        io_axi_r_ready = 1'b1;
        @(posedge clk);
        #1 io_axi_r_ready = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        @(negedge clk);
        io_axi_w_data = d; io_axi_w_strb = s; io_axi_w_last = l; io_axi_w_valid = 1'b1;
        #1;
        while (!io_axi_w_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk_val("w_ready_seen", 32'(io_axi_w_ready), 32'd1);
        @(posedge clk);
        #1 io_axi_w_valid = 1'b0;
        chk_val("w_pulse_we", 32'(io_sram_we), 32'd1);
        chk_val("w_pulse_ready_low", 32'(io_axi_w_ready), 32'd0);
        $display("W  data=%h strb=%b sram_addr=%h", d, s, io_sram_addr);
    endtask

    task automatic b_take(input logic [7:0] eid, input logic [1:0] er);
        int n = 0;
        @(negedge clk);
        while (!io_axi_b_valid && n < 40) begin @(negedge clk); n++; end
        chk_val("b_valid_seen", 32'(io_axi_b_valid), 32'd1);
        chk_val("b_id", 32'(io_axi_b_id), 32'(eid));
        chk_val("b_resp", 32'(io_axi_b_resp), 32'(er));
        $display("B  id=%h resp=%b", io_axi_b_id, io_axi_b_resp);
        io_axi_b_ready = 1'b1;
        @(posedge clk);
        #1 io_axi_b_ready = 1'b0;
        @(negedge clk);
        chk_val("b_single", 32'(io_axi_b_valid), 32'd0);
    endtask

    task automatic chk_wlog(input int idx, input logic [19:0] ea, input logic [31:0] ed, input logic [3:0] em);
        chk_val("wr_addr", idx < wa_log.size() ? 32'(wa_log[idx]) : 32'hFFFF_FFFF, 32'(ea));
        chk_val("wr_data", idx < wd_log.size() ? wd_log[idx] : 32'hFFFF_FFFF, ed);
        chk_val("wr_mask", idx < wm_log.size() ? 32'(wm_log[idx]) : 32'hFFFF_FFFF, 32'(em));
    endtask

    task automatic chk_rlog(input int idx, input logic [19:0] ea);
        chk_val("rd_addr", idx < rd_log.size() ? 32'(rd_log[idx]) : 32'hFFFF_FFFF, 32'(ea));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        rst_n = 1'b0;
        io_axi_ar_id = '0; io_axi_ar_addr = '0; io_axi_ar_len = '0; io_axi_ar_size = 3'b010;
        io_axi_ar_burst = 2'b01; io_axi_ar_valid = 1'b0; io_axi_r_ready = 1'b0;
        io_axi_aw_id = '0; io_axi_aw_addr = '0; io_axi_aw_len = '0; io_axi_aw_size = 3'b010;
        io_axi_aw_burst = 2'b01; io_axi_aw_valid = 1'b0;
        io_axi_w_data = '0; io_axi_w_strb = '0; io_axi_w_last = 1'b0; io_axi_w_valid = 1'b0;
        io_axi_b_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_ar_ready", 32'(io_axi_ar_ready), 32'd0);
        chk_val("rst_aw_ready", 32'(io_axi_aw_ready), 32'd0);
        chk_val("rst_r_valid", 32'(io_axi_r_valid), 32'd0);
        chk_val("rst_b_valid", 32'(io_axi_b_valid), 32'd0);
        chk_val("rst_sram_en", 32'(io_sram_en), 32'd0);
        chk_val("rst_r_data", io_axi_r_data, 32'd0);
        rst_n = 1'b1;
        #1 chk_val("rdy_before_edge", 32'(io_axi_ar_ready), 32'd0);
        @(posedge clk);
        #1 chk_val("rdy_after_edge", 32'(io_axi_ar_ready), 32'd1);

        // simultaneous request: read first, then the write on the next IDLE
        @(negedge clk);
        io_axi_ar_id = 8'h11; io_axi_ar_addr = 32'h10; io_axi_ar_len = 8'd0; io_axi_ar_valid = 1'b1;
        io_axi_aw_id = 8'h22; io_axi_aw_addr = 32'h100; io_axi_aw_len = 8'd3; io_axi_aw_valid = 1'b1;
        rd_log.delete();
        #1;
        chk_val("conflict_ar_ready", 32'(io_axi_ar_ready), 32'd1);
        chk_val("conflict_aw_ready", 32'(io_axi_aw_ready), 32'd0);
        @(posedge clk);
        #1 hs_cyc = cyc;
        io_axi_ar_valid = 1'b0;
        r_beat(32'hDEAD_BEEF, 1'b1, 2'b00, 8'h11, 0);
        chk_val("rd_latency", 32'(rv_cyc - hs_cyc + 1), 32'd2);
        chk_val("rd_count_single", 32'(rd_log.size()), 32'd1);
        chk_rlog(0, 20'h00004);
        @(negedge clk);
        #1 chk_val("aw_grant_next", 32'(io_axi_aw_ready), 32'd1);
        wa_log.delete(); wd_log.delete(); wm_log.delete();
        @(posedge clk);
        #1 io_axi_aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) w_beat(32'h1000_0000 + 32'(i), 4'b1111, i == 3);
        b_take(8'h22, 2'b00);
        chk_val("wr_count_incr", 32'(wa_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_wlog(i, 20'h40 + 20'(i), 32'h1000_0000 + 32'(i), 4'b1111);

        // FIXED burst keeps the word address
        wa_log.delete(); wd_log.delete(); wm_log.delete();
        aw_send(8'h55, 32'h20, 8'd1, 3'b010, 2'b00);
        w_beat(32'hAAAA_0001, 4'b0101, 1'b0);
        w_beat(32'hBBBB_0002, 4'b1010, 1'b1);
        b_take(8'h55, 2'b00);
        chk_wlog(0, 20'h8, 32'hAAAA_0001, 4'b0101);
        chk_wlog(1, 20'h8, 32'hBBBB_0002, 4'b1010);

        // backpressure on beat 2 of a 4-beat read
        rd_log.delete();
        ar_send(8'h3C, 32'h200, 8'd3, 3'b010, 2'b01);
        r_beat(32'hC0D0_0080, 1'b0, 2'b00, 8'h3C, 0);
        r_beat(32'hC0D0_0081, 1'b0, 2'b00, 8'h3C, 5);
        r_beat(32'hC0D0_0082, 1'b0, 2'b00, 8'h3C, 0);
        r_beat(32'hC0D0_0083, 1'b1, 2'b00, 8'h3C, 0);
        chk_val("rd_count_bp", 32'(rd_log.size()), 32'd4);
        chk_rlog(3, 20'h00083);

        // word address wraps modulo 2^20
        rd_log.delete();
        ar_send(8'h4D, 32'h003F_FFFC, 8'd1, 3'b010, 2'b01);
        r_beat(32'hC0DF_FFFF, 1'b0, 2'b00, 8'h4D, 0);
        r_beat(32'hC0D0_0000, 1'b1, 2'b00, 8'h4D, 0);
        chk_rlog(0, 20'hFFFFF);
        chk_rlog(1, 20'h00000);

        // second conflict goes to the write
        @(negedge clk);
        io_axi_ar_id = 8'h77; io_axi_ar_addr = 32'h10; io_axi_ar_len = 8'd0; io_axi_ar_valid = 1'b1;
        io_axi_aw_id = 8'h66; io_axi_aw_addr = 32'h40; io_axi_aw_len = 8'd0; io_axi_aw_burst = 2'b01;
        io_axi_aw_valid = 1'b1;
        #1;
        chk_val("alt_aw_ready", 32'(io_axi_aw_ready), 32'd1);
        chk_val("alt_ar_ready", 32'(io_axi_ar_ready), 32'd0);
        @(posedge clk);
        #1 io_axi_aw_valid = 1'b0;
        w_beat(32'hCAFE_0000, 4'b1111, 1'b1);
        b_take(8'h66, 2'b00);
        #1 chk_val("alt_ar_after", 32'(io_axi_ar_ready), 32'd1);
        @(posedge clk);
        #1 io_axi_ar_valid = 1'b0;
        r_beat(32'hDEAD_BEEF, 1'b1, 2'b00, 8'h77, 0);

        // narrow-size read: SLVERR only when the error option is built in
        rd_log.delete();
        ar_send(8'h44, 32'h10, 8'd1, 3'b000, 2'b01);
`ifdef AXI_SRAM_BRIDGE_ERRCHK_EN
        r_beat(32'h0, 1'b0, 2'b10, 8'h44, 0);
        r_beat(32'h0, 1'b1, 2'b10, 8'h44, 0);
        chk_val("err_rd_count", 32'(rd_log.size()), 32'd0);
`else
        r_beat(32'hDEAD_BEEF, 1'b0, 2'b00, 8'h44, 0);
        r_beat(32'hC0D0_0005, 1'b1, 2'b00, 8'h44, 0);
        chk_val("size_rd_count", 32'(rd_log.size()), 32'd2);
`endif

        // reset in the middle of a write burst, during a write pulse
        aw_send(8'h33, 32'h300, 8'd3, 3'b010, 2'b01);
        w_beat(32'h3000_0000, 4'b1111, 1'b0);
        w_beat(32'h3000_0001, 4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_val("mid_rst_en", 32'(io_sram_en), 32'd0);
        chk_val("mid_rst_we", 32'(io_sram_we), 32'd0);
        chk_val("mid_rst_wmask", 32'(io_sram_wmask), 32'd0);
        chk_val("mid_rst_w_ready", 32'(io_axi_w_ready), 32'd0);
        chk_val("mid_rst_aw_ready", 32'(io_axi_aw_ready), 32'd0);
        chk_val("mid_rst_b_id", 32'(io_axi_b_id), 32'd0);
        chk_val("mid_rst_r_data", io_axi_r_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        io_axi_b_ready = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (io_axi_b_valid) bcnt++;
        end
        io_axi_b_ready = 1'b0;
        chk_val("no_b_after_rst", 32'(bcnt), 32'd0);
        chk_val("idle_after_rst", 32'(io_axi_ar_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
